microcode_sequencer: RTL
========================

# microcode_sequencer

Drives the microcode control-word ROM and gates its output onto the control bus. It consumes the opcode nibble from the instruction register and the carry/zero flags. It forms the 8-bit ROM address {opcode, step} and sequences each microstep over two clock cycles to absorb the ROM's one-cycle read latency. It also ends instructions early, substitutes jump words for taken conditional jumps (JC/JZ), and stops on HLT.

## Interface
Parameters:
- MAX_STEPS, 8: microsteps per instruction before forced wrap; legal 3..16.

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  sequencing enable; low holds the sequencer in ADDR with no control word issued.
- opcode  input  4  instruction-register high nibble.
- flag_c  input  1  carry flag from flags register.
- flag_z  input  1  zero flag from flags register.
- rom_addr  output  8  {opcode, step} to the microcode ROM (combinational from opcode and step register).
- rom_data  input  16  control word from ROM; valid in the cycle after rom_addr is presented.
- ctrl  output  16  control word to datapath; bit order HLT,MI,RI,RO,IO,II,AI,AO,EO,SU,BI,OI,CE,CO,J,FI (bit 15..0).
- ctrl_en  output  1  high when ctrl is valid; datapath acts on the rising edge ending that cycle.
- step  output  4  current microstep.
- halted  output  1  high once HLT has executed.
- instr_count  output  16  count of completed instructions; wraps at 0xFFFF -> 0x0000.

## Operation
- States: ADDR, EXEC, HALT.
- ADDR: ctrl=0, ctrl_en=0. If run=1, go to EXEC next edge; else stay in ADDR.
- EXEC: effective word w = rom_data, except w = 0x0802 (IO|J) when step==2 and either opcode==0x7 with flag_c=1, or opcode==0x8 with flag_z=1. ctrl=w, ctrl_en=1.
- EXEC exit, evaluated in priority order:
  - w[15]=1: go to HALT. step is held; instr_count is incremented.
  - step>=2 and w==0x0000: step<=0, instr_count+1, go to ADDR. This is early termination; the zero word is still issued with ctrl_en=1 and is harmless.
  - step==MAX_STEPS-1: step<=0, instr_count+1, go to ADDR.
  - Otherwise: step<=step+1, go to ADDR.
- Early termination is never applied at steps 0 and 1. Fetch words there are unconditional.
- HALT: ctrl=0, ctrl_en=0, halted=1, rom_addr held. Only rst leaves HALT; run is ignored.
- The opcode is sampled live. II is issued at step 1, so steps ≥2 use the newly loaded opcode. Steps 0/1 are identical for all opcodes.
- Flags are sampled only in the EXEC cycle of step 2.

## Timing
- Reset values (the cycle after rst is sampled high): state=ADDR, step=0, rom_addr={opcode,0x0}, ctrl=0x0000, ctrl_en=0, halted=0, instr_count=0.
- rst has priority over all transitions, including a mid-instruction EXEC and HALT. The EXEC word in the reset cycle is still driven combinationally, but no state is committed.
- Each microstep is exactly 2 cycles: ADDR then EXEC. With run held high, ctrl_en toggles 0,1,0,1…
- A cycle-by-cycle fetch with run=1 from reset:
  - cycle 0 ADDR, addr 0x00
  - cycle 1 EXEC, ctrl=0x4004 (MI|CO)
  - cycle 2 ADDR, addr 0x01
  - cycle 3 EXEC, ctrl=0x1408 (RO|II|CE)
- Latency of an instruction with k issued words is 2k cycles. instr_count updates on the edge ending the last EXEC.
- Dropping run during EXEC does not abort that EXEC. The stall takes effect at the following ADDR.

## Test plan
- LDA (opcode 1, ROM words 4004,1408,4800,1200,0000): run=1 from reset -> ctrl_en sequence issues 0x4004,0x1408,0x4800,0x1200,0x0000. step returns to 0 after 10 cycles; instr_count=1.
- JC taken vs not taken: opcode 7, flag_c=1 -> step 2 issues 0x0802 then terminates at step 3. With flag_c=0 -> step 2 issues 0x0000 and terminates at step 2. Repeat for JZ (opcode 8) with flag_z.
- HLT: opcode F -> step 2 issues 0x8000, then halted=1, ctrl_en stays 0 for 20+ cycles with run=1, instr_count incremented once. rst then clears halted and restarts at addr 0x00.
- Forced wrap: MAX_STEPS=4, ROM returns nonzero 0x0001 for all steps -> step sequence 0,1,2,3,0 with instr_count incrementing at each wrap.
- run stall: deassert run during EXEC of step 1 -> that word (0x1408) still issues. The sequencer then holds ADDR with rom_addr {op,2} and ctrl_en=0 until run=1, resuming with step 2.
- Reset mid-instruction: assert rst during EXEC of step 3 -> next cycle step=0, ctrl=0, ctrl_en=0, instr_count=0.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: addresses the control ROM as {opcode, step} and issues one
// control word per two-cycle microstep, with jump substitution, early end and halt.
module microcode_sequencer #(
    parameter int unsigned MAX_STEPS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ctrl,
    output logic        ctrl_en,
    output logic [3:0]  step,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_STEP = 4'(MAX_STEPS - 1);
    localparam logic [15:0] JUMP_WORD = 16'h0802;
    localparam logic [3:0]  OP_JC     = 4'h7;
    localparam logic [3:0]  OP_JZ     = 4'h8;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] count_q, count_d;
    logic        jump_taken;
    logic [15:0] word_w;

    // Flags matter only at step 2, where JC/JZ place their conditional word.
    always_comb begin
        jump_taken = (step_q == 4'd2) &&
                     (((opcode == OP_JC) && flag_c) || ((opcode == OP_JZ) && flag_z));
        word_w     = jump_taken ? JUMP_WORD : rom_data;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        unique case (state_q)
            S_ADDR: begin
                if (run) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (word_w[15]) begin
                    state_d = S_HALT;
                    count_d = count_q + 16'd1;
                end else if ((step_q >= 4'd2) && (word_w == '0)) begin
                    state_d = S_ADDR;
                    step_d  = '0;
                    count_d = count_q + 16'd1;
                end else if (step_q == LAST_STEP) begin
                    state_d = S_ADDR;
                    step_d  = '0;
                    count_d = count_q + 16'd1;
                end else begin
                    state_d = S_ADDR;
                    step_d  = step_q + 4'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_ADDR;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ADDR;
            step_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    // Outputs decode straight from state registers; ctrl must follow rom_data in EXEC.
    always_comb begin
        rom_addr    = {opcode, step_q};
        ctrl        = (state_q == S_EXEC) ? word_w : '0;
        ctrl_en     = (state_q == S_EXEC);
        halted      = (state_q == S_HALT);
        step        = step_q;
        instr_count = count_q;
    end

endmodule
